// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: NPCOp codes and fetch FSM state encodings shared by the fetch unit.
package instr_fetch_pkg;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

`ifdef IF_ALIGN_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ISSUE, S_FAULT} fetch_state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ISSUE} fetch_state_t;
`endif

endpackage

// File: rtl/instr_fetch_npc.sv
// instr_fetch_npc: combinational next-PC select (pc+4, branch, jump, jr/jalr), wrapping modulo 2^AW.
module instr_fetch_npc
    import instr_fetch_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] pc,
    input  logic [25:0]   target,
    input  logic [1:0]    npc_op,
    input  logic [31:0]   rs_data,
    output logic [AW-1:0] pc_plus4,
    output logic [AW-1:0] next_pc
);

    logic [AW-1:0] br_off;

    assign pc_plus4 = pc + AW'(4);
    assign br_off   = {{(AW-18){target[15]}}, target[15:0], 2'b00};
    assign next_pc  = npc_op == NPC_PLUS4  ? pc_plus4 :
                      npc_op == NPC_BRANCH ? pc_plus4 + br_off :
                      npc_op == NPC_JUMP   ? {pc_plus4[AW-1:28], target, 2'b00} :
                                             AW'(rs_data);

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner and imem fetch FSM (IDLE/REQ/WAIT/ISSUE); IF_ALIGN_CHECK_EN adds a sticky misaligned-PC FAULT state.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int          AW       = 32,
    parameter logic [AW-1:0] RESET_PC = AW'(32'h0000_3000)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_rsp_valid,
    input  logic [31:0]   imem_rsp_data,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [31:0]   instr,
    output logic [5:0]    Op,
    output logic [5:0]    Funct,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_plus4,
    input  logic [1:0]    NPCOp,
    input  logic [31:0]   rs_data,
    output logic          fetch_fault
);

    fetch_state_t  state;
    logic [AW-1:0] next_pc;

    instr_fetch_npc #(.AW(AW)) u_npc (
        .pc       (pc),
        .target   (instr[25:0]),
        .npc_op   (NPCOp),
        .rs_data  (rs_data),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc)
    );

    assign imem_req_valid = state == S_REQ;
    assign instr_valid    = state == S_ISSUE;
    assign Op             = instr[31:26];
    assign Funct          = instr[5:0];

`ifdef IF_ALIGN_CHECK_EN
    logic fault_q;
    assign imem_addr   = pc;
    assign fetch_fault = fault_q;
`else
    assign imem_addr   = {pc[AW-1:2], 2'b00};
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            instr <= '0;
`ifdef IF_ALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: if (imem_req_ready) state <= S_WAIT;
                S_WAIT: if (imem_rsp_valid) begin
                    instr <= imem_rsp_data;
                    state <= S_ISSUE;
                end
                S_ISSUE: if (instr_ready) begin
                    pc <= next_pc;
`ifdef IF_ALIGN_CHECK_EN
                    state   <= next_pc[1:0] != 2'b00 ? S_FAULT : S_REQ;
                    fault_q <= next_pc[1:0] != 2'b00;
`else
                    state <= S_REQ;
`endif
                end
                default: state <= state;
            endcase
        end
    end

endmodule
